// File: rtl/ttl_74646_sync.sv
// Octal registered bus transceiver with optional inversion, tri-state ports and a
// dead-time turnaround state machine that separates every change of drive direction.
module ttl_74646_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned INVERT      = 0,
    parameter int unsigned DELAY_RISE  = 0,
    parameter int unsigned DELAY_FALL  = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             G_bar,
    input  logic             DIR,
    input  logic             SAB,
    input  logic             SBA,
    input  logic             CE_AB,
    input  logic             CE_BA,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             Busy
);

    typedef enum logic [1:0] {
        StOff,
        StAb,
        StBa,
        StTurn
    } state_e;

    // Counter holds remaining dead cycles minus one; zero dead time bypasses TURN.
    localparam logic [3:0] TurnLoad = (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);

    // Edge delays belong to timed board models; synthesized hardware adds none.
    if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_delays_not_modelled
    end

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] reg_a_q, reg_b_q;
    logic [WIDTH-1:0] a_src, b_src;
    logic [WIDTH-1:0] a_data, b_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StOff: begin
                if (!G_bar) begin
                    state_d = DIR ? StAb : StBa;
                end
            end
            StAb: begin
                if (G_bar) begin
                    state_d = StOff;
                end else if (!DIR) begin
                    if (TURN_CYCLES == 0) begin
                        state_d = StBa;
                    end else begin
                        state_d = StTurn;
                        cnt_d   = TurnLoad;
                    end
                end
            end
            StBa: begin
                if (G_bar) begin
                    state_d = StOff;
                end else if (DIR) begin
                    if (TURN_CYCLES == 0) begin
                        state_d = StAb;
                    end else begin
                        state_d = StTurn;
                        cnt_d   = TurnLoad;
                    end
                end
            end
            StTurn: begin
                if (G_bar) begin
                    state_d = StOff;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // DIR sampled here, so a reverted direction returns to the original side.
                    state_d = DIR ? StAb : StBa;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            state_q <= StOff;
            cnt_q   <= 4'd0;
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (CE_AB) begin
                reg_a_q <= A_in;
            end
            if (CE_BA) begin
                reg_b_q <= B_in;
            end
        end
    end

    always_comb begin
        b_src  = SAB ? reg_a_q : A_in;
        a_src  = SBA ? reg_b_q : B_in;
        b_data = (INVERT != 0) ? ~b_src : b_src;
        a_data = (INVERT != 0) ? ~a_src : a_src;
    end

    // Enables decode from a single state register, so both sides can never drive together.
    assign B_out = (state_q == StAb) ? b_data : {WIDTH{1'bz}};
    assign A_out = (state_q == StBa) ? a_data : {WIDTH{1'bz}};
    assign Busy  = (state_q == StTurn);

endmodule

// File: tb/tb_ttl_74646_sync.sv
// Bench for ttl_74646_sync: three instances (plain T=2, inverting T=3, plain T=0) share stimulus
// and are checked against a dead-time countdown model; released buses read all ones via pullups.
module tb_ttl_74646_sync;

    logic       clk = 1'b0;
    logic       clear_bar, g_bar, dir, sab, sba, ce_ab, ce_ba;
    logic [7:0] a_in, b_in;
    wire  [23:0] a_bus, b_bus;
    wire  [2:0]  busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: enabled flag, driven side (1 = B side), dead cycles left, stored registers.
    bit       m_en   [3];
    bit       m_side [3];
    int       m_dead [3];
    bit [7:0] m_ra   [3];
    bit [7:0] m_rb   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 24; g++) begin : g_pull
        pullup pu_a (a_bus[g]);
        pullup pu_b (b_bus[g]);
    end

    ttl_74646_sync #(.WIDTH(8), .TURN_CYCLES(2), .INVERT(0)) dut0 (
        .Clk(clk), .Clear_bar(clear_bar), .G_bar(g_bar), .DIR(dir), .SAB(sab), .SBA(sba),
        .CE_AB(ce_ab), .CE_BA(ce_ba), .A_in(a_in), .B_in(b_in),
        .A_out(a_bus[7:0]), .B_out(b_bus[7:0]), .Busy(busy[0])
    );
    ttl_74646_sync #(.WIDTH(8), .TURN_CYCLES(3), .INVERT(1)) dut1 (
        .Clk(clk), .Clear_bar(clear_bar), .G_bar(g_bar), .DIR(dir), .SAB(sab), .SBA(sba),
        .CE_AB(ce_ab), .CE_BA(ce_ba), .A_in(a_in), .B_in(b_in),
        .A_out(a_bus[15:8]), .B_out(b_bus[15:8]), .Busy(busy[1])
    );
    ttl_74646_sync #(.WIDTH(8), .TURN_CYCLES(0), .INVERT(0)) dut2 (
        .Clk(clk), .Clear_bar(clear_bar), .G_bar(g_bar), .DIR(dir), .SAB(sab), .SBA(sba),
        .CE_AB(ce_ab), .CE_BA(ce_ba), .A_in(a_in), .B_in(b_in),
        .A_out(a_bus[23:16]), .B_out(b_bus[23:16]), .Busy(busy[2])
    );

    function automatic int turn_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 0;
    endfunction

    function automatic bit [7:0] fx(input int i, input bit [7:0] v);
        return (i == 1) ? ~v : v;
    endfunction

    task automatic model_edge(input int i);
        if (!clear_bar) begin
            m_en[i]   = 1'b0;
            m_dead[i] = 0;
            m_ra[i]   = 8'h00;
            m_rb[i]   = 8'h00;
        end else begin
            if (ce_ab) m_ra[i] = a_in;
            if (ce_ba) m_rb[i] = b_in;
            if (g_bar) begin
                m_en[i]   = 1'b0;
                m_dead[i] = 0;
            end else if (!m_en[i]) begin
                m_en[i]   = 1'b1;
                m_side[i] = dir;
                m_dead[i] = 0;
            end else if (m_dead[i] > 0) begin
                m_dead[i]--;
                if (m_dead[i] == 0) m_side[i] = dir;
            end else if (dir != m_side[i]) begin
                if (turn_of(i) == 0) m_side[i] = dir;
                else m_dead[i] = turn_of(i);
            end
        end
    endtask

    task automatic check(input string tag, input int i, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            bit       drv_b, drv_a, bsy;
            bit [7:0] exp_a, exp_b;
            bsy   = m_en[i] && (m_dead[i] > 0);
            drv_b = m_en[i] && (m_dead[i] == 0) && m_side[i];
            drv_a = m_en[i] && (m_dead[i] == 0) && !m_side[i];
            exp_b = drv_b ? fx(i, sab ? m_ra[i] : a_in) : 8'hFF;
            exp_a = drv_a ? fx(i, sba ? m_rb[i] : b_in) : 8'hFF;
            check("b_out", i, b_bus[i*8 +: 8], exp_b);
            check("a_out", i, a_bus[i*8 +: 8], exp_a);
            check("busy", i, {7'd0, busy[i]}, {7'd0, bsy});
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        check_all();
    endtask

    initial begin
        clear_bar = 1'b0; g_bar = 1'b1; dir = 1'b1; sab = 1'b0; sba = 1'b0;
        ce_ab = 1'b0; ce_ba = 1'b0; a_in = 8'h00; b_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            m_en[i] = 1'b0; m_side[i] = 1'b0; m_dead[i] = 0; m_ra[i] = 8'h00; m_rb[i] = 8'h00;
        end
        step();
        // Reset priority over capture and enable.
        ce_ab = 1'b1; a_in = 8'hFF; g_bar = 1'b0;
        step();
        // Enable AB; stored path must show the cleared register.
        clear_bar = 1'b1; ce_ab = 1'b0; sab = 1'b1; a_in = 8'h3C;
        step();
        sab = 1'b0;
        #1 check_all();
        step();
        // Capture then stored path.
        ce_ab = 1'b1; a_in = 8'h81;
        step();
        ce_ab = 1'b0; sab = 1'b1; a_in = 8'h00;
        step();
        // Reversal with dead time.
        sab = 1'b0; b_in = 8'hA5; dir = 1'b0;
        repeat (4) step();
        // Reverted direction during dead time.
        dir = 1'b1;
        step();
        dir = 1'b0;
        step();
        dir = 1'b1;
        repeat (4) step();
        // Abort during dead time.
        dir = 1'b0;
        step();
        g_bar = 1'b1;
        repeat (2) step();
        // Stored B path in BA.
        g_bar = 1'b0; ce_ba = 1'b1; b_in = 8'h5A;
        repeat (2) step();
        ce_ba = 1'b0; sba = 1'b1; b_in = 8'h00;
        step();

        for (int n = 0; n < 400; n++) begin
            clear_bar = ($urandom_range(0, 39) != 0);
            g_bar     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) dir = ~dir;
            sab   = 1'($urandom_range(0, 1));
            sba   = 1'($urandom_range(0, 1));
            ce_ab = ($urandom_range(0, 2) == 0);
            ce_ba = ($urandom_range(0, 2) == 0);
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            #1 check_all();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ttl_74646_sync.md
# ttl_74646_sync

Single-clock octal registered bus transceiver with inverting option and tri-state outputs on both ports. It is the bidirectional, storing counterpart to the one-way buffers in the 7400 library. Data passes between an A bus and a B bus either in real time or from a stored register. A turnaround state machine guarantees dead time, with both sides high-Z, whenever the drive direction reverses. It sits between two shared tri-state buses, for example a CPU data bus and a peripheral bus, in board-level models.

## Interface
- WIDTH, 8, bus width per side
- TURN_CYCLES, 2, dead-time cycles on a direction reversal; legal range 0..15
- INVERT, 0, 1 = data inverted in both directions
- DELAY_RISE, 0, output rise delay
- DELAY_FALL, 0, output fall delay

Ports:
- Clk  input  1  rising-edge clock
- Clear_bar  input  1  synchronous reset, active-low; one clock, reset synchronous and active-low
- G_bar  input  1  output enable, active-low
- DIR  input  1  1 = drive B from A; 0 = drive A from B
- SAB  input  1  source for B_out: 0 = real-time A_in, 1 = stored RegA
- SBA  input  1  source for A_out: 0 = real-time B_in, 1 = stored RegB
- CE_AB  input  1  capture A_in into RegA at the clock edge
- CE_BA  input  1  capture B_in into RegB at the clock edge
- A_in  input  WIDTH  A bus sample
- B_in  input  WIDTH  B bus sample
- A_out  output  WIDTH  A bus drive, tri-state
- B_out  output  WIDTH  B bus drive, tri-state
- Busy  output  1  high while in TURN

## Operation
- State register has four states: OFF, AB, BA and TURN. A 4-bit turnaround counter Cnt accompanies it.
- Reset: Clear_bar low at an edge forces state = OFF, Cnt = 0, RegA = RegB = 0. Reset overrides every other input, including CE_AB and CE_BA.
- OFF: A_out and B_out both high-Z; Busy = 0.
  - G_bar = 0 at the edge → AB if DIR = 1, else BA. No dead time is applied.
- AB: B_out driven; A_out high-Z.
  - G_bar = 1 → OFF.
  - Else DIR = 0 → TURN with Cnt = TURN_CYCLES−1. If TURN_CYCLES = 0, go directly to BA.
- BA: mirror of AB. A_out driven; B_out high-Z; DIR = 1 triggers the turnaround.
- TURN: both outputs high-Z; Busy = 1.
  - G_bar = 1 → OFF.
  - Else Cnt ≠ 0 → Cnt decrements.
  - Else Cnt = 0 → AB if DIR = 1, else BA. DIR is sampled at this edge, so a direction that reverted during TURN returns to the original side.
- Drive data (combinational from current inputs and registers):
  - B_out = f(SAB ? RegA : A_in)
  - A_out = f(SBA ? RegB : B_in)
  - f inverts all bits when INVERT = 1.
- Capture: RegA ← A_in on CE_AB, and RegB ← B_in on CE_BA, in every state, independent of G_bar and DIR.
  - Storing from the bus being driven while SAB = 1 is legal. The register receives the value present before the edge.
- Never both outputs driven simultaneously, in any state or input combination.
- Undriven outputs are all-bits Z, full WIDTH.

## Timing
- State-dependent enables change only after a rising edge. Data through an enabled path is zero-cycle (combinational) plus DELAY_RISE/DELAY_FALL.
- G_bar low sampled at edge k in OFF: the selected side drives from edge k onward.
- G_bar high sampled at edge k: both sides are Z from edge k onward.
- Reversal sampled at edge k from AB, TURN_CYCLES = T ≥ 1:
  - B_out is Z from edge k.
  - Busy is high for exactly T cycles.
  - A_out drives from edge k+T.
- Register capture at edge k: a stored path (SAB/SBA = 1) shows the new value from edge k.
- Clear_bar low at edge k mid-TURN or mid-drive: both outputs Z and Busy = 0 from edge k; stored paths read 0 after re-enable.

## Test plan
- Reset then enable:
  - Stimulus: Clear_bar low one edge; G_bar = 0, DIR = 1, SAB = 0, A_in = 0x3C, INVERT = 0.
  - Response: B_out = 0x3C from the next edge; A_out = Z; Busy = 0.
- Reversal with dead time:
  - Stimulus: in AB with TURN_CYCLES = 2, DIR → 0 at edge k; B_in = 0xA5.
  - Response: both sides Z for edges k to k+2; Busy = 1 for 2 cycles; A_out = 0xA5 from edge k+2.
- Stored path and capture:
  - Stimulus: CE_AB pulse with A_in = 0x81; then SAB = 1, A_in = 0x00.
  - Response: B_out = 0x81. With INVERT = 1 the response is B_out = 0x7E.
- Abort during TURN:
  - Stimulus: G_bar → 1 while Busy = 1.
  - Response: state OFF at the next edge; both sides stay Z; Busy = 0.
- Reverted direction and zero dead time:
  - Stimulus: DIR toggles 1→0→1 within TURN.
  - Response: exit to AB with B_out driven.
  - Stimulus: TURN_CYCLES = 0.
  - Response: reversal switches sides in one edge with no Busy.
- Reset priority:
  - Stimulus: Clear_bar low together with CE_AB and A_in = 0xFF.
  - Response: RegA = 0x00; outputs Z.
